// File: rtl/stopwatch_core.sv
// stopwatch_core: hh:mm:ss.cc stopwatch with start/stop, lap and clear keys.
//
// Ports
//   i_clk          single clock, all logic on its rising edge
//   i_rst          synchronous active-high reset
//   i_start_stop   debounced key level (async); rising edge = start/stop request
//   i_lap          debounced key level (async); rising edge = lap request
//   i_clear        debounced key level (async); rising edge = clear request
//   o_hour         hours 0..99 (binary)
//   o_minute       minutes 0..59 (binary)
//   o_second       seconds 0..59 (binary)
//   o_cs           centiseconds 0..99 (binary)
//   o_record       two-cycle lap strobe; the LCD record stage captures on its falling edge
//   o_running      high while in RUN
//
// Parameters
//   TICK_DIV       i_clk cycles per centisecond
//   HOLD_CYC       cycles the displayed snapshot stays frozen after a lap (>= 4)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | stopped, counters and prescaler at zero
// ST_RUN  | prescaler and time counters advancing
// ST_PAUSE| stopped, counters and prescaler phase held for resume
module stopwatch_core #(
    parameter int TICK_DIV = 500000,
    parameter int HOLD_CYC = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start_stop,
    input  logic       i_lap,
    input  logic       i_clear,
    output logic [7:0] o_hour,
    output logic [7:0] o_minute,
    output logic [7:0] o_second,
    output logic [7:0] o_cs,
    output logic       o_record,
    output logic       o_running
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    // [0] first sync flop, [1] second sync flop, [2] history flop
    logic [2:0]     r_ss_pipe;
    logic [2:0]     r_lap_pipe;
    logic [2:0]     r_clr_pipe;
    logic           w_ss_evt;
    logic           w_lap_evt;
    logic           w_clr_evt;

    logic [PW-1:0]  r_presc;
    logic [7:0]     r_hour;
    logic [7:0]     r_min;
    logic [7:0]     r_sec;
    logic [7:0]     r_cs;
    logic           w_tick;
    logic           w_do_clear;
    logic           w_lap_ok;

    logic [HW-1:0]  r_hold;
    logic [1:0]     r_rec;

    // Reset to all ones so a key already held high at reset release is
    // seen as a steady level, not a rising edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ss_pipe  <= 3'b111;
            r_lap_pipe <= 3'b111;
            r_clr_pipe <= 3'b111;
        end else begin
            r_ss_pipe  <= {r_ss_pipe[1:0], i_start_stop};
            r_lap_pipe <= {r_lap_pipe[1:0], i_lap};
            r_clr_pipe <= {r_clr_pipe[1:0], i_clear};
        end
    end

    assign w_ss_evt  = r_ss_pipe[1]  & ~r_ss_pipe[2];
    assign w_lap_evt = r_lap_pipe[1] & ~r_lap_pipe[2];
    assign w_clr_evt = r_clr_pipe[1] & ~r_clr_pipe[2];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Start/stop wins over clear; a lap is judged independently so it can
    // act in the same cycle as a start/stop transition.
    always_comb begin
        w_state_next = r_state;
        w_do_clear   = 1'b0;
        w_lap_ok     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_evt) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_lap_ok = w_lap_evt && (r_hold == '0);
                if (w_ss_evt) begin
                    w_state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                w_lap_ok = w_lap_evt && (r_hold == '0);
                if (w_ss_evt) begin
                    w_state_next = ST_RUN;
                end else if (w_clr_evt) begin
                    w_state_next = ST_IDLE;
                    w_do_clear   = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_tick = (r_state == ST_RUN) && (r_presc == PRESC_LAST);

    // Prescaler is only advanced in RUN, so PAUSE keeps the sub-centisecond
    // phase; only clear or reset zero it.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_do_clear) begin
            r_presc <= '0;
            r_hour  <= 8'd0;
            r_min   <= 8'd0;
            r_sec   <= 8'd0;
            r_cs    <= 8'd0;
        end else begin
            if (r_state == ST_RUN) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end
            if (w_tick) begin
                if (r_cs == 8'd99) begin
                    r_cs <= 8'd0;
                    if (r_sec == 8'd59) begin
                        r_sec <= 8'd0;
                        if (r_min == 8'd59) begin
                            r_min  <= 8'd0;
                            r_hour <= (r_hour == 8'd99) ? 8'd0 : r_hour + 8'd1;
                        end else begin
                            r_min <= r_min + 8'd1;
                        end
                    end else begin
                        r_sec <= r_sec + 8'd1;
                    end
                end else begin
                    r_cs <= r_cs + 8'd1;
                end
            end
        end
    end

    // The output registers normally copy the live count (one cycle late),
    // which makes the copy taken at a lap edge the snapshot itself. r_hold
    // then counts the freeze window down; while it is above 1 the outputs
    // keep that snapshot, and while it is non-zero further laps are ignored.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold   <= '0;
            r_rec    <= 2'b00;
            o_hour   <= 8'd0;
            o_minute <= 8'd0;
            o_second <= 8'd0;
            o_cs     <= 8'd0;
        end else begin
            if (w_lap_ok) begin
                r_hold <= HOLD_LOAD;
                r_rec  <= 2'b11;
            end else begin
                if (r_hold != '0) begin
                    r_hold <= r_hold - 1'b1;
                end
                r_rec <= {1'b0, r_rec[1]};
            end
            if (r_hold <= HW'(1)) begin
                o_hour   <= r_hour;
                o_minute <= r_min;
                o_second <= r_sec;
                o_cs     <= r_cs;
            end
        end
    end

    assign o_record  = r_rec[0];
    assign o_running = (r_state == ST_RUN);

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with TICK_DIV=4, HOLD_CYC=8.
// Inputs change and outputs are sampled on the falling clock edge.
// A key raised at a falling edge is acted on at the third rising edge after it.
module tb_stopwatch_core;

    localparam int TICK_DIV = 4;
    localparam int HOLD_CYC = 8;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start_stop = 1'b0;
    logic       i_lap = 1'b0;
    logic       i_clear = 1'b0;
    logic [7:0] o_hour;
    logic [7:0] o_minute;
    logic [7:0] o_second;
    logic [7:0] o_cs;
    logic       o_record;
    logic       o_running;

    int n_checks = 0;
    int n_pass   = 0;

    stopwatch_core #(
        .TICK_DIV (TICK_DIV),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start_stop (i_start_stop),
        .i_lap        (i_lap),
        .i_clear      (i_clear),
        .o_hour       (o_hour),
        .o_minute     (o_minute),
        .o_second     (o_second),
        .o_cs         (o_cs),
        .o_record     (o_record),
        .o_running    (o_running)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s, input int c);
        chk({tag, ".hour"}, int'(o_hour), h);
        chk({tag, ".min"},  int'(o_minute), m);
        chk({tag, ".sec"},  int'(o_second), s);
        chk({tag, ".cs"},   int'(o_cs), c);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Returns at the falling edge right after the edge that acts on the keys.
    task automatic press(input logic k_ss, input logic k_lap, input logic k_clr);
        i_start_stop = k_ss;
        i_lap        = k_lap;
        i_clear      = k_clr;
        step(3);
        i_start_stop = 1'b0;
        i_lap        = 1'b0;
        i_clear      = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step(2);
        i_rst = 1'b0;
        step(3);
    endtask

    initial begin
        // reset state
        step(3);
        chk_time("reset", 0, 0, 0, 0);
        chk("reset.running", int'(o_running), 0);
        chk("reset.record", int'(o_record), 0);
        i_rst = 1'b0;
        step(3);

        // basic run: 4 cycles per cs, cs->sec and sec->min carries
        press(1'b1, 1'b0, 1'b0);
        chk("start.running", int'(o_running), 1);
        step(400);
        chk_time("run400", 0, 0, 0, 99);
        step(1);
        chk_time("run401", 0, 0, 1, 0);
        chk("run401.running", int'(o_running), 1);
        step(23599);
        chk_time("run24000", 0, 0, 59, 99);
        step(1);
        chk_time("run24001", 0, 1, 0, 0);

        // lap at 2.37, freeze window, second lap ignored
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        step(947);
        chk_time("prelap", 0, 0, 2, 36);
        i_lap = 1'b1;
        step(1);
        chk("lap.rec_e1", int'(o_record), 0);
        step(1);
        chk("lap.rec_e2", int'(o_record), 0);
        step(1);
        chk("lap.rec_n1", int'(o_record), 1);
        chk_time("lap.snap", 0, 0, 2, 37);
        i_lap = 1'b0;
        step(1);
        chk("lap.rec_n2", int'(o_record), 1);
        chk("lap.cs_n2", int'(o_cs), 37);
        i_lap = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("lap.rec_low", int'(o_record), 0);
            chk("lap.frozen_cs", int'(o_cs), 37);
            chk("lap.frozen_sec", int'(o_second), 2);
            if (i == 2) i_lap = 1'b0;
        end
        step(1);
        chk_time("lap.resume", 0, 0, 2, 39);
        chk("lap.rec_after", int'(o_record), 0);

        // pause keeps prescaler phase
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        step(399);
        press(1'b1, 1'b0, 1'b0);
        chk("pause.running", int'(o_running), 0);
        chk_time("pause.t0", 0, 0, 1, 0);
        step(100);
        chk_time("pause.t100", 0, 0, 1, 0);
        press(1'b1, 1'b0, 1'b0);
        chk("resume.running", int'(o_running), 1);
        step(2);
        chk_time("resume.e2", 0, 0, 1, 0);
        step(1);
        chk_time("resume.e3", 0, 0, 1, 1);

        // clear ignored in RUN, honoured in PAUSE
        press(1'b0, 1'b0, 1'b1);
        chk("clr_run.running", int'(o_running), 1);
        chk("clr_run.sec", int'(o_second), 1);
        press(1'b1, 1'b0, 1'b0);
        chk("stop2.running", int'(o_running), 0);
        press(1'b0, 1'b0, 1'b1);
        chk("clr_pause.running", int'(o_running), 0);
        step(1);
        chk_time("clr_pause", 0, 0, 0, 0);

        // start/stop + clear together in PAUSE resumes with counts kept
        press(1'b1, 1'b0, 1'b0);
        step(40);
        press(1'b1, 1'b0, 1'b0);
        step(2);
        press(1'b1, 1'b0, 1'b1);
        chk("ss_clr.running", int'(o_running), 1);
        chk_time("ss_clr", 0, 0, 0, 10);
        step(2);
        chk("ss_clr.cs_next", int'(o_cs), 11);

        // lap in IDLE gives no record
        press(1'b1, 1'b0, 1'b0);
        step(2);
        press(1'b0, 1'b0, 1'b1);
        step(1);
        press(1'b0, 1'b1, 1'b0);
        chk("idle_lap.rec0", int'(o_record), 0);
        step(1);
        chk("idle_lap.rec1", int'(o_record), 0);
        chk_time("idle_lap", 0, 0, 0, 0);

        // lap together with stop: both act
        press(1'b1, 1'b0, 1'b0);
        step(10);
        press(1'b1, 1'b1, 1'b0);
        chk("lap_stop.running", int'(o_running), 0);
        chk("lap_stop.rec", int'(o_record), 1);
        chk("lap_stop.cs", int'(o_cs), 3);

        // key held high across reset release
        i_start_stop = 1'b1;
        i_rst = 1'b1;
        step(2);
        i_rst = 1'b0;
        step(6);
        chk("held_key.running", int'(o_running), 0);
        i_start_stop = 1'b0;
        step(3);
        chk("held_key.release", int'(o_running), 0);

        // reset while the record strobe is high
        press(1'b1, 1'b0, 1'b0);
        step(20);
        press(1'b0, 1'b1, 1'b0);
        chk("rst_rec.before", int'(o_record), 1);
        i_rst = 1'b1;
        step(1);
        chk("rst_rec.rec", int'(o_record), 0);
        chk("rst_rec.running", int'(o_running), 0);
        chk_time("rst_rec", 0, 0, 0, 0);
        i_rst = 1'b0;
        step(1);
        chk("rst_rec.after1", int'(o_record), 0);
        step(3);
        chk("rst_rec.after4", int'(o_record), 0);
        chk("rst_rec.idle", int'(o_running), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
